// File: rtl/ascon_pkg.sv
// Shared ASCON types, FSM encoding and round constants for the sequential
// permutation-based stages (init, AD, plaintext, finalization).
package ascon_pkg;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PT,
        S_EMIT,
        S_PERM,
        S_PAD,
        S_DONE
    } fsm_state_t;

    localparam logic [7:0] PAD_BYTE  = 8'h80;
    localparam logic [3:0] P6_FIRST  = 4'd6;

    // Constants for all 12 rounds of p12; p6 uses entries 6..11.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hf0;
            4'd1:    return 8'he1;
            4'd2:    return 8'hd2;
            4'd3:    return 8'hc3;
            4'd4:    return 8'hb4;
            4'd5:    return 8'ha5;
            4'd6:    return 8'h96;
            4'd7:    return 8'h87;
            4'd8:    return 8'h78;
            4'd9:    return 8'h69;
            4'd10:   return 8'h5a;
            4'd11:   return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced 5-bit S-box,
// and the per-word linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [7:0]   rc,
    output ascon_state_t state_out
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    always_comb begin
        a0 = state_in.x0 ^ state_in.x4;
        a1 = state_in.x1;
        a2 = state_in.x2 ^ {56'd0, rc} ^ state_in.x1;
        a3 = state_in.x3;
        a4 = state_in.x4 ^ state_in.x3;

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        // x1 picks up x0 before x0 absorbs x4
        c1 = b1 ^ b0;
        c0 = b0 ^ b4;
        c3 = b3 ^ b2;
        c2 = ~b2;
        c4 = b4;

        state_out.x0 = c0 ^ rotr64(c0, 19) ^ rotr64(c0, 28);
        state_out.x1 = c1 ^ rotr64(c1, 61) ^ rotr64(c1, 39);
        state_out.x2 = c2 ^ rotr64(c2, 1)  ^ rotr64(c2, 6);
        state_out.x3 = c3 ^ rotr64(c3, 10) ^ rotr64(c3, 17);
        state_out.x4 = c4 ^ rotr64(c4, 7)  ^ rotr64(c4, 41);
    end

endmodule

// File: rtl/ascon_pt_encrypt.sv
// ASCON-128 plaintext phase: absorbs 64-bit blocks into x0, emits ciphertext,
// and iterates p6 one round per cycle between blocks.
//
// state     | meaning
// IDLE      | waiting for the post-AD state
// WAIT_PT   | ready for the next plaintext block
// EMIT      | presenting a ciphertext block until accepted
// PERM      | running p6, one round per cycle
// PAD       | lone padding block after a full final block
// DONE      | presenting the final state to finalization
module ascon_pt_encrypt
    import ascon_pkg::*;
#(
    parameter int RATE_BYTES  = 8,
    parameter int PERM_ROUNDS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        start_empty,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [63:0] pt,
    input  logic        pt_last,
    input  logic [3:0]  pt_bytes,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [63:0] ct,
    output logic [3:0]  ct_bytes,
    output logic        ct_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);

    localparam logic [3:0]  FULL_BYTES = 4'(RATE_BYTES);
    localparam logic [2:0]  LAST_ROUND = 3'(PERM_ROUNDS - 1);
    localparam logic [63:0] PAD_WORD   = {PAD_BYTE, 56'd0};

    fsm_state_t   fsm, fsm_next;
    ascon_state_t st, st_next, round_out;
    logic [2:0]   round_cnt, round_next;
    logic         full_last, full_next;
    logic [63:0]  ct_q, ct_next;
    logic [3:0]   ct_bytes_q, ct_bytes_next;
    logic         ct_last_q, ct_last_next;

    logic [3:0]   n_eff, n_inv, pad_idx;
    logic [63:0]  pt_mask, pad_word, x0_absorb;

    ascon_round u_round (
        .state_in  (st),
        .rc        (round_const(P6_FIRST + {1'b0, round_cnt})),
        .state_out (round_out)
    );

    // Illegal byte counts on a final block fall back to a full block.
    always_comb begin
        n_eff = FULL_BYTES;
        if (pt_last && pt_bytes != 4'd0 && pt_bytes < FULL_BYTES)
            n_eff = pt_bytes;
        n_inv     = FULL_BYTES - n_eff;
        pad_idx   = 4'd7 - n_eff;
        pt_mask   = {64{1'b1}} << {n_inv[2:0], 3'b000};
        pad_word  = (n_eff == FULL_BYTES) ? 64'd0 : ({56'd0, PAD_BYTE} << {pad_idx[2:0], 3'b000});
        x0_absorb = st.x0 ^ (pt & pt_mask) ^ pad_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= S_IDLE;
            st         <= '0;
            round_cnt  <= '0;
            full_last  <= 1'b0;
            ct_q       <= '0;
            ct_bytes_q <= '0;
            ct_last_q  <= 1'b0;
        end else begin
            fsm        <= fsm_next;
            st         <= st_next;
            round_cnt  <= round_next;
            full_last  <= full_next;
            ct_q       <= ct_next;
            ct_bytes_q <= ct_bytes_next;
            ct_last_q  <= ct_last_next;
        end
    end

    always_comb begin
        fsm_next      = fsm;
        st_next       = st;
        round_next    = round_cnt;
        full_next     = full_last;
        ct_next       = ct_q;
        ct_bytes_next = ct_bytes_q;
        ct_last_next  = ct_last_q;

        case (fsm)
            S_IDLE: begin
                if (start_valid) begin
                    st_next.x0 = x0;
                    st_next.x1 = x1;
                    st_next.x2 = x2;
                    st_next.x3 = x3;
                    st_next.x4 = x4;
                    if (start_empty) begin
                        st_next.x0 = x0 ^ PAD_WORD;
                        fsm_next   = S_DONE;
                    end else begin
                        fsm_next   = S_WAIT_PT;
                    end
                end
            end
            S_WAIT_PT: begin
                if (pt_valid) begin
                    st_next.x0    = x0_absorb;
                    ct_next       = x0_absorb & pt_mask;
                    ct_bytes_next = n_eff;
                    ct_last_next  = pt_last;
                    full_next     = pt_last && (n_eff == FULL_BYTES);
                    round_next    = '0;
                    fsm_next      = S_EMIT;
                end
            end
            S_EMIT: begin
                if (ct_ready)
                    fsm_next = (ct_last_q && !full_last) ? S_DONE : S_PERM;
            end
            S_PERM: begin
                st_next = round_out;
                if (round_cnt == LAST_ROUND) begin
                    round_next = '0;
                    fsm_next   = full_last ? S_PAD : S_WAIT_PT;
                end else begin
                    round_next = round_cnt + 3'd1;
                end
            end
            S_PAD: begin
                st_next.x0 = st.x0 ^ PAD_WORD;
                full_next  = 1'b0;
                fsm_next   = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    fsm_next = S_IDLE;
            end
            default: fsm_next = S_IDLE;
        endcase
    end

    assign start_ready = (fsm == S_IDLE);
    assign pt_ready    = (fsm == S_WAIT_PT);
    assign ct_valid    = (fsm == S_EMIT);
    assign out_valid   = (fsm == S_DONE);
    assign ct          = ct_q;
    assign ct_bytes    = ct_bytes_q;
    assign ct_last     = ct_last_q;
    assign y0          = st.x0;
    assign y1          = st.x1;
    assign y2          = st.x2;
    assign y3          = st.x3;
    assign y4          = st.x4;

endmodule

// File: doc/ascon_pt_encrypt.md
Name: ascon_pt_encrypt

Overview:
- Sequential ASCON-128 plaintext-phase engine, directly downstream of the associated-data stage.
- Accepts the 320-bit state after AD absorption and domain separation, i.e. with x4 LSB already flipped.
- Streams 64-bit plaintext blocks in, streams ciphertext blocks out, and runs p6 iteratively between blocks at one round per cycle.
- Hands the final padded state to finalization.

Parameters:
- RATE_BYTES, 8, rate in bytes; fixed at 8 for ASCON-128, and must not be overridden.
- PERM_ROUNDS, 6, intermediate permutation round count; round constants 0x96,0x87,0x78,0x69,0x5a,0x4b.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  initial state present.
- start_ready  out  1  high only in IDLE.
- start_empty  in  1  qualifies start: plaintext length is zero.
- x0..x4  in  64 each  state from the AD stage.
- pt_valid  in  1  plaintext block present.
- pt_ready  out  1  high only in WAIT_PT.
- pt  in  64  plaintext block; byte 0 is bits [63:56].
- pt_last  in  1  final block.
- pt_bytes  in  4  valid bytes in the last block, 1..8; ignored when pt_last=0.
- ct_valid  out  1  ciphertext block valid.
- ct_ready  in  1  ciphertext accepted.
- ct  out  64  ciphertext; bytes beyond pt_bytes are zero.
- ct_bytes  out  4  valid bytes in ct.
- ct_last  out  1  final ciphertext block.
- out_valid  out  1  final state valid.
- out_ready  in  1  final state accepted.
- y0..y4  out  64 each  state for finalization.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE; state registers are cleared to 0.
  - ct_valid, out_valid, ct_last = 0; ct = 0; ct_bytes = 0.
  - Reset mid-operation abandons the message; no partial ct or state is emitted.
- FSM states: IDLE, WAIT_PT, EMIT, PERM, PAD, DONE.
- IDLE:
  - On start_valid, load x0..x4.
  - If start_empty=1: x0 ^= 0x8000_0000_0000_0000, go to DONE.
  - Otherwise go to WAIT_PT.
- WAIT_PT, on pt_valid && pt_ready:
  - Non-last block:
    - x0 ^= pt.
    - ct = new x0; ct_bytes = 8; ct_last = 0.
    - Go to EMIT, then PERM.
  - Last block, n = pt_bytes < 8:
    - x0 ^= (pt masked to the top n bytes) | (0x80 at byte n).
    - ct = top n bytes of new x0, lower bytes zeroed; ct_bytes = n; ct_last = 1.
    - Go to EMIT, then DONE.
  - Last block, n = 8:
    - x0 ^= pt; ct = new x0; ct_bytes = 8; ct_last = 1.
    - Go to EMIT, then PERM, then PAD, then DONE.
  - pt_bytes of 0 or >8 with pt_last=1 is illegal; it is treated as 8.
- EMIT:
  - ct_valid = 1, with ct, ct_bytes and ct_last held stable until ct_ready.
  - Leave EMIT on the handshake cycle.
  - ct_valid rises exactly 1 cycle after the pt handshake.
- PERM:
  - Exactly 6 cycles; round counter 0..5 selects the constant.
  - Each cycle: state <= round(state, rc).
  - On round 5, go to WAIT_PT, or to PAD if a full last block is pending.
  - pt_ready stays low throughout.
- PAD:
  - One cycle: x0 ^= 0x8000_0000_0000_0000, no permutation.
  - Go to DONE.
- DONE:
  - out_valid = 1; y0..y4 = state, held until out_ready.
  - Then go to IDLE.
  - Do not apply a key XOR or finalization; the downstream block owns that.
- Throughput: one non-last block per 8 cycles when ct_ready is held high (accept, EMIT, 6×PERM).
- Simultaneous events: start_valid outside IDLE and pt_valid outside WAIT_PT are ignored and not consumed.
- Width rules: all XORs are 64-bit bitwise; the round counter is 3 bits and never wraps past 5.

Decomposition:
- Shared package ascon_pkg holds:
  - the 320-bit state typedef (five 64-bit words);
  - the FSM state enum;
  - the round constant table for all 12 rounds (f0..4b), with p6 indexing entries 6..11;
  - PAD_BYTE = 8'h80.
- One sub-module: ascon_round, a single combinational round (constant add, 5-bit S-box, linear diffusion layer).
  - It is instantiated once and iterated by the FSM.
  - It is shareable with the initialization and finalization stages.

Test Plan:
- Empty message:
  - Stimulus: start with x0..x4 = 0 and start_empty=1.
  - Required: out_valid 1 cycle after accept; y0 = 0x8000000000000000, y1..y4 = 0; no ct_valid.
- Single partial block:
  - Stimulus: state 0, pt = 0x0123456789ABCDEF, pt_last=1, pt_bytes=3.
  - Required: ct = 0x0123450000000000, ct_bytes = 3, ct_last = 1.
  - Required: y0 = 0x0123458000000000, y1..y4 = 0; no PERM cycles.
- Full last block:
  - Stimulus: state 0, pt = 0xFFFFFFFFFFFFFFFF, pt_bytes=8, pt_last=1.
  - Required: ct = 0xFFFFFFFFFFFFFFFF.
  - Required: exactly 6 PERM cycles, then a PAD cycle; y equals a software p6 of the state with x0 = all-ones, then x0 ^= 0x80<<56.
- Two blocks with ct backpressure:
  - Stimulus: hold ct_ready low for 5 cycles on block 1.
  - Required: ct stays stable throughout the stall; pt_ready stays low until EMIT and 6 PERM cycles complete.
  - Required: final state matches the reference model.
- Async reset in PERM round 3:
  - Required: all outputs are 0 immediately, without waiting for a clock edge; next start is accepted normally.
- Illegal traffic:
  - Stimulus: start_valid during WAIT_PT; pt_valid during PERM.
  - Required: neither is consumed; start_ready and pt_ready read 0.
